ddr_cmd_scheduler: RTL and testbench
====================================

# ddr_cmd_scheduler

Command scheduler for the DDR controller. After initialization completes, it arbitrates between two host requesters and steps the command-state sequence (ACTIVE → READ/WRITE with auto-precharge → wait states) that the command generator turns into DDR pins. It also schedules periodic AUTO REFRESH. It drives `cmd_state` and `ctrl_addr` straight into the command generator.

## Interface
- `T_RCD`, 2: ACTIVE-to-READ/WRITE delay in cycles, ≥1.
- `CAS_LAT`, 2: cycles spent in WAIT_CAS_LATENCY, ≥1.
- `BURST_CYC`, 4: data-burst cycles for BL8 on DDR, ≥1.
- `T_WR`, 2: write-recovery cycles, ≥1.
- `T_RFC`, 8: AUTO REFRESH-to-next-command delay, ≥2.
- `REF_INTERVAL`, 780: cycles between refresh requests, ≥16.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `init_done` in 1: high once the init sequencer has reached READY; must stay high afterwards.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in 25: {ba[24:23], row[22:10], col[9:0]}.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when valid&ready.
- `cmd_state` out 4: current command state, fed to the command generator.
- `ctrl_addr` out 25: latched address of the request in service.
- `done` out 1: one-cycle pulse at the end of each access.
- `done_id` out 1: requester served; valid when `done` is high.
- `done_we` out 1: access type; valid when `done` is high.
- `refresh_overrun` out 1: sticky flag; see Configuration.

## Operation
- State encodings:
  - IDLE=0, ACTIVE=1, WAIT_tRCD=2, READ=3, WAIT_CAS_LATENCY=4, WAIT_END_OF_R_BURST=5
  - WRITE=6, WAIT_END_OF_W_BURST=7, WAIT_WRITE_RECOVERY=8, AUTOREFRESH=9, WAIT_tRFC=10
  - DONE=11, REFRESH_DONE=12
- Reset values:
  - `cmd_state`=IDLE, `ctrl_addr`=0.
  - `done`, `done_id`, `done_we`, `refresh_overrun` all 0; readies 0.
  - Refresh counter = 0, refresh_pending = 0, last_grant = 1 (so req0 wins the first tie).
- While `init_done`=0: the state is held at IDLE, readies are 0, and the refresh counter is held at 0.
- Refresh counter:
  - Increments every cycle while `init_done`=1.
  - At REF_INTERVAL−1 it wraps to 0 and sets refresh_pending.
  - refresh_pending clears on entry to AUTOREFRESH.
- In IDLE, arbitration priority is refresh_pending first, then requests:
  - If refresh_pending: both readies are 0 and the next state is AUTOREFRESH.
  - Else if exactly one requester is valid, it is granted.
  - Else if both are valid, grant goes to the requester that is not last_grant (round-robin).
- `reqN_ready` = IDLE & `init_done` & ~refresh_pending & grant==N.
  - It may depend combinationally on the other port's valid, never on its own.
- On a handshake: `ctrl_addr`, we, and id are latched, last_grant is updated, and the next state is ACTIVE.
- Read path: ACTIVE(1) → WAIT_tRCD(T_RCD−1; skipped if T_RCD=1) → READ(1) → WAIT_CAS_LATENCY(CAS_LAT) → WAIT_END_OF_R_BURST(BURST_CYC) → DONE(1) → IDLE.
- Write path: ACTIVE(1) → WAIT_tRCD(T_RCD−1) → WRITE(1) → WAIT_END_OF_W_BURST(BURST_CYC) → WAIT_WRITE_RECOVERY(T_WR) → DONE(1) → IDLE.
- Refresh path: AUTOREFRESH(1) → WAIT_tRFC(T_RFC−1) → REFRESH_DONE(1) → IDLE.
- Precharge is implicit: the command generator sets A10 (auto-precharge), so there is no PRECHARGE state.
- `done`, `done_id` and `done_we` are asserted while `cmd_state`==DONE.
- A refresh that becomes due mid-access waits; it is serviced on the next IDLE, ahead of any request.
- One shared down-counter, loaded on each state entry, times all wait states. Its width is ≥ clog2 of the largest parameter.

## Timing
- `cmd_state` and `ctrl_addr` are registered. They change only on `clk` rising edges, or asynchronously on reset.
- Handshake in cycle n → `cmd_state`=ACTIVE in cycle n+1.
- With default parameters:
  - Read: DONE in cycle n+10, IDLE in n+11, next handshake possible in n+11.
  - Write: DONE in cycle n+10.
  - Refresh: occupies 9 cycles IDLE-to-IDLE (AUTOREFRESH, WAIT_tRFC×7, REFRESH_DONE).
- Reset asserted mid-operation aborts immediately to reset values. No command completion is reported.

## Configuration
- `DDR_SCHED_OVERRUN_DETECT_EN` defined:
  - `refresh_overrun` sets when the counter wraps while refresh_pending is already 1.
  - It stays set until reset.
- Not defined: `refresh_overrun` is tied to 0 and no detection logic is built. The port is present either way.

## Test plan
- Hold `init_done`=0 for 50 cycles with req0 valid → readies stay 0, `cmd_state`=0, no refresh.
- Single read: req0 with addr=0x1A2_B3C4, we=0 → state sequence 1,2,3,4,4,5,5,5,5,11,0; `ctrl_addr`=0x1A2B3C4; `done_id`=0, `done_we`=0.
- Single write: req1 with we=1 → sequence 1,2,6,7×4,8×2,11,0; `done_id`=1, `done_we`=1.
- Both requesters valid continuously → grants alternate 0,1,0,1; each handshake falls 11 cycles after the previous one.
- Refresh due during a read (REF_INTERVAL=16) → the read completes, then 9,10×7,12; no ready asserts until back in IDLE.
- With the macro defined and REF_INTERVAL=16, req0 keeping the scheduler busy past two wraps → `refresh_overrun`=1 and it stays 1. Without the macro it stays 0.

Source files
------------

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: two-port round-robin arbiter, access/refresh sequencer.
// Optional refresh overrun detection: define DDR_SCHED_OVERRUN_DETECT_EN.
module ddr_cmd_scheduler #(
  parameter int T_RCD        = 2,
  parameter int CAS_LAT      = 2,
  parameter int BURST_CYC    = 4,
  parameter int T_WR         = 2,
  parameter int T_RFC        = 8,
  parameter int REF_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_we,
  input  logic        req1_we,
  input  logic [24:0] req0_addr,
  input  logic [24:0] req1_addr,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [3:0]  cmd_state,
  output logic [24:0] ctrl_addr,
  output logic        done,
  output logic        done_id,
  output logic        done_we,
  output logic        refresh_overrun
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ACTIVE     = 4'd1,
    S_WAIT_RCD   = 4'd2,
    S_READ       = 4'd3,
    S_WAIT_CAS   = 4'd4,
    S_WAIT_RBST  = 4'd5,
    S_WRITE      = 4'd6,
    S_WAIT_WBST  = 4'd7,
    S_WAIT_WR    = 4'd8,
    S_AREF       = 4'd9,
    S_WAIT_RFC   = 4'd10,
    S_DONE       = 4'd11,
    S_REF_DONE   = 4'd12
  } state_e;

  localparam int M1  = (T_RCD > CAS_LAT) ? T_RCD : CAS_LAT;
  localparam int M2  = (M1 > BURST_CYC) ? M1 : BURST_CYC;
  localparam int M3  = (M2 > T_WR) ? M2 : T_WR;
  localparam int MX  = (M3 > T_RFC) ? M3 : T_RFC;
  localparam int CW  = $clog2(MX + 1);
  localparam int RCW = $clog2(REF_INTERVAL);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RCW-1:0]  ref_q, ref_d;
  logic            pend_q, pend_d;
  logic [24:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic            id_q, id_d;
  logic            lg_q, lg_d;

  logic idle_ok;
  logic gnt0, gnt1;
  logic hs0, hs1;
  logic wrap;
  logic enter_aref;
  logic cnt_zero;

  // Grant for one port looks only at the other port's valid.
  assign idle_ok    = (state_q == S_IDLE) & init_done & ~pend_q;
  assign gnt0       = ~req1_valid | lg_q;
  assign gnt1       = ~req0_valid | ~lg_q;
  assign req0_ready = idle_ok & gnt0;
  assign req1_ready = idle_ok & gnt1;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;

  assign cnt_zero   = (cnt_q == '0);
  assign wrap       = init_done & (ref_q == RCW'(REF_INTERVAL - 1));
  assign enter_aref = (state_q == S_IDLE) & init_done & pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - CW'(1);
    addr_d  = addr_q;
    we_d    = we_q;
    id_d    = id_q;
    lg_d    = lg_q;
    unique case (state_q)
      S_IDLE: begin
        if (enter_aref) begin
          state_d = S_AREF;
        end else if (hs1) begin
          state_d = S_ACTIVE;
          addr_d  = req1_addr;
          we_d    = req1_we;
          id_d    = 1'b1;
          lg_d    = 1'b1;
        end else if (hs0) begin
          state_d = S_ACTIVE;
          addr_d  = req0_addr;
          we_d    = req0_we;
          id_d    = 1'b0;
          lg_d    = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (T_RCD == 1) begin
          state_d = we_q ? S_WRITE : S_READ;
        end else begin
          state_d = S_WAIT_RCD;
          cnt_d   = CW'(T_RCD - 2);
        end
      end
      S_WAIT_RCD: begin
        if (cnt_zero) state_d = we_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        state_d = S_WAIT_CAS;
        cnt_d   = CW'(CAS_LAT - 1);
      end
      S_WAIT_CAS: begin
        if (cnt_zero) begin
          state_d = S_WAIT_RBST;
          cnt_d   = CW'(BURST_CYC - 1);
        end
      end
      S_WAIT_RBST: begin
        if (cnt_zero) state_d = S_DONE;
      end
      S_WRITE: begin
        state_d = S_WAIT_WBST;
        cnt_d   = CW'(BURST_CYC - 1);
      end
      S_WAIT_WBST: begin
        if (cnt_zero) begin
          state_d = S_WAIT_WR;
          cnt_d   = CW'(T_WR - 1);
        end
      end
      S_WAIT_WR: begin
        if (cnt_zero) state_d = S_DONE;
      end
      S_AREF: begin
        state_d = S_WAIT_RFC;
        cnt_d   = CW'(T_RFC - 2);
      end
      S_WAIT_RFC: begin
        if (cnt_zero) state_d = S_REF_DONE;
      end
      S_DONE:     state_d = S_IDLE;
      S_REF_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A wrap coinciding with refresh entry is a fresh request, not an overrun.
  always_comb begin
    ref_d  = ref_q;
    pend_d = pend_q;
    if (init_done) ref_d = wrap ? '0 : ref_q + RCW'(1);
    if (wrap) pend_d = 1'b1;
    else if (enter_aref) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      lg_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      id_q    <= id_d;
      lg_q    <= lg_d;
    end
  end

`ifdef DDR_SCHED_OVERRUN_DETECT_EN
  logic ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else if (wrap & pend_q & ~enter_aref) begin
      ovr_q <= 1'b1;
    end
  end

  assign refresh_overrun = ovr_q;
`else
  assign refresh_overrun = 1'b0;
`endif

  assign cmd_state = state_q;
  assign ctrl_addr = addr_q;
  assign done      = (state_q == S_DONE);
  assign done_id   = id_q;
  assign done_we   = we_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: access table, round-robin,
// refresh preemption, overrun flag and reset abort.
module tb_ddr_cmd_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init, v0, v1, we0, we1;
  logic [24:0] a0, a1;
  logic        rdy0, rdy1, dn, did, dwe, ovr;
  logic [3:0]  st;
  logic [24:0] caddr;

  logic        r_rst, r_init, r_v0, r_v1, r_we0, r_we1;
  logic [24:0] r_a0, r_a1;
  logic        r_rdy0, r_rdy1, r_dn, r_did, r_dwe, r_ovr;
  logic [3:0]  r_st;
  logic [24:0] r_caddr;

`ifdef DDR_SCHED_OVERRUN_DETECT_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  ddr_cmd_scheduler dut (
    .clk(clk), .rst(rst), .init_done(init),
    .req0_valid(v0), .req1_valid(v1),
    .req0_we(we0), .req1_we(we1),
    .req0_addr(a0), .req1_addr(a1),
    .req0_ready(rdy0), .req1_ready(rdy1),
    .cmd_state(st), .ctrl_addr(caddr),
    .done(dn), .done_id(did), .done_we(dwe),
    .refresh_overrun(ovr)
  );

  ddr_cmd_scheduler #(.REF_INTERVAL(16), .BURST_CYC(20)) dut_r (
    .clk(clk), .rst(r_rst), .init_done(r_init),
    .req0_valid(r_v0), .req1_valid(r_v1),
    .req0_we(r_we0), .req1_we(r_we1),
    .req0_addr(r_a0), .req1_addr(r_a1),
    .req0_ready(r_rdy0), .req1_ready(r_rdy1),
    .cmd_state(r_st), .ctrl_addr(r_caddr),
    .done(r_dn), .done_id(r_did), .done_we(r_dwe),
    .refresh_overrun(r_ovr)
  );

  typedef struct {
    logic        id;
    logic        we;
    logic [24:0] addr;
    logic [43:0] seq;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t r);
    int k;
    logic [3:0] e;
    if (r.id) begin
      v1 = 1'b1; we1 = r.we; a1 = r.addr;
    end else begin
      v0 = 1'b1; we0 = r.we; a0 = r.addr;
    end
    #1;
    k = 0;
    while (((r.id ? rdy1 : rdy0) !== 1'b1) && k < 20) begin
      tick();
      k++;
    end
    chk("hs_ready", r.id ? rdy1 : rdy0, 1);
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      e = r.seq[4*i +: 4];
      chk("state", st, e);
      chk("done", dn, e == 4'd11);
      if (e == 4'd1) chk("ctrl_addr", caddr, r.addr);
      if (e == 4'd11) begin
        chk("done_id", did, r.id);
        chk("done_we", dwe, r.we);
      end
      if (i < 10) tick();
    end
  endtask

  vec_t vt[4];
  int   exp_r[38];
  int   g_id[4];
  int   g_cy[4];
  int   ng;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{id: 1'b0, we: 1'b0, addr: 25'h1A2B3C4, seq: 44'h0B5_5554_4321};
    vt[1] = '{id: 1'b1, we: 1'b1, addr: 25'h0ABCDEF, seq: 44'h0B8_8777_7621};
    vt[2] = '{id: 1'b1, we: 1'b0, addr: 25'h1FFFFFF, seq: 44'h0B5_5554_4321};
    vt[3] = '{id: 1'b0, we: 1'b1, addr: 25'h0000000, seq: 44'h0B8_8777_7621};

    for (int c = 0; c < 38; c++) exp_r[c] = 0;
    exp_r[1] = 1; exp_r[2] = 2; exp_r[3] = 3;
    exp_r[4] = 4; exp_r[5] = 4;
    for (int c = 6; c <= 25; c++) exp_r[c] = 5;
    exp_r[26] = 11; exp_r[27] = 0; exp_r[28] = 9;
    for (int c = 29; c <= 35; c++) exp_r[c] = 10;
    exp_r[36] = 12; exp_r[37] = 0;

    rst = 1'b0; init = 1'b0; v0 = 1'b0; v1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; a0 = '0; a1 = '0;
    r_rst = 1'b0; r_init = 1'b0; r_v0 = 1'b0; r_v1 = 1'b0;
    r_we0 = 1'b0; r_we1 = 1'b0; r_a0 = '0; r_a1 = '0;
    #12;

    chk("rst_state", st, 0);
    chk("rst_addr", caddr, 0);
    chk("rst_done", dn, 0);
    chk("rst_done_id", did, 0);
    chk("rst_done_we", dwe, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_rdy", {rdy1, rdy0}, 0);
    chk("rst_r_state", r_st, 0);

    tick();
    rst = 1'b1;
    v0 = 1'b1;
    a0 = 25'h0123456;
    #1;
    for (int c = 0; c < 50; c++) begin
      chk("init_rdy0", rdy0, 0);
      chk("init_rdy1", rdy1, 0);
      chk("init_state", st, 0);
      tick();
    end

    v0 = 1'b0;
    init = 1'b1;
    for (int i = 0; i < 4; i++) apply(vt[i]);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
    a0 = 25'h0111111; a1 = 25'h1222222;
    for (int i = 0; i < 4; i++) begin
      g_id[i] = -1;
      g_cy[i] = -100;
    end
    ng = 0;
    #1;
    for (int c = 0; c < 46; c++) begin
      if (ng < 4 && v0 && rdy0) begin
        g_id[ng] = 0; g_cy[ng] = c; ng++;
      end else if (ng < 4 && v1 && rdy1) begin
        g_id[ng] = 1; g_cy[ng] = c; ng++;
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("rr_first_cycle", g_cy[0], 0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_id", g_id[i], i % 2);
      if (i > 0) chk("rr_spacing", g_cy[i] - g_cy[i-1], 11);
    end

    rst = 1'b0;
    tick();
    rst = 1'b1;
    v0 = 1'b1; we0 = 1'b1; a0 = 25'h1555555;
    #1;
    chk("abort_rdy", rdy0, 1);
    tick();
    v0 = 1'b0;
    chk("abort_active", st, 1);
    for (int c = 0; c < 4; c++) tick();
    chk("abort_mid", st, 7);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", st, 0);
    chk("abort_addr", caddr, 0);
    chk("abort_done", dn, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 2) rst = 1'b1;
      chk("abort_no_done", dn, 0);
    end

    tick();
    r_rst = 1'b1;
    tick();
    r_init = 1'b1;
    r_v0 = 1'b1; r_we0 = 1'b0; r_a0 = 25'h0ABC123;
    #1;
    chk("ref_hs_rdy", r_rdy0, 1);
    for (int c = 1; c <= 37; c++) begin
      tick();
      if (c == 1) r_v0 = 1'b0;
      #1;
      chk("ref_state", r_st, exp_r[c]);
      chk("ref_rdy", r_rdy0 | r_rdy1, 0);
    end
    chk("ref_done_seen_addr", r_caddr, 25'h0ABC123);
    chk("ovr_early", r_ovr, 0);

    r_v0 = 1'b1;
    for (int c = 0; c < 100; c++) tick();
    chk("ovr_set", r_ovr, EXP_OVR);
    r_v0 = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    chk("ovr_sticky", r_ovr, EXP_OVR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
